// File: rtl/key_scan_debounce.sv
// rtl/key_scan_debounce.sv - multi-key debouncer with press/release/long/repeat pulses
module key_scan_debounce #(
   parameter int                  NUM_KEYS       = 4,
   parameter int                  TICK_DIV       = 50000,
   parameter int                  DEBOUNCE_TICKS = 20,
   parameter int                  LONG_TICKS     = 1000,
   parameter int                  REPEAT_TICKS   = 200,
   parameter logic [NUM_KEYS-1:0] REPEAT_EN      = {NUM_KEYS{1'b1}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_down,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_repeat
);

   localparam int TICK_W   = $clog2(TICK_DIV);
   localparam int DB_W     = $clog2(DEBOUNCE_TICKS + 1);
   localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_TICKS - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_TICKS - 1);
   localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_TICKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   logic [NUM_KEYS-1:0] sync_a;
   logic [NUM_KEYS-1:0] raw_n;
   logic [NUM_KEYS-1:0] pressed_raw;
   logic [TICK_W-1:0]   tick_cnt;
   logic                tick;

   // Two-flop synchroniser; resets to the released (high) level so a key
   // held through reset is seen as a fresh press afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= '1;
         raw_n  <= '1;
      end else begin
         sync_a <= key_in;
         raw_n  <= sync_a;
      end
   end

   assign pressed_raw = ~raw_n;
   assign tick        = (tick_cnt == TICK_LAST);

   // Free-running millisecond prescaler shared by every channel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      logic [DB_W-1:0]   db_cnt;
      logic [HOLD_W-1:0] hold_cnt;
      state_t            state;
      logic              differ;
      logic              accept;
      logic              down_q;
      logic              press_q;
      logic              release_q;
      logic              long_q;
      logic              repeat_q;

      // The debounced level is the FSM's own key_down, so a change is any
      // disagreement between it and the synchronised pin.
      assign differ = (pressed_raw[i] != down_q);
      assign accept = differ && tick && (db_cnt == DB_LAST);

      // Count ticks of continuous disagreement; any agreement restarts it.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            db_cnt <= '0;
         end else if (!differ || accept) begin
            db_cnt <= '0;
         end else if (tick) begin
            db_cnt <= db_cnt + 1'b1;
         end
      end

      // Channel FSM: level, edge pulses and hold timing; release beats
      // a long/repeat terminal count landing on the same tick.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            down_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     state    <= ST_PRESSED;
                     down_q   <= 1'b1;
                     press_q  <= 1'b1;
                     hold_cnt <= '0;
                  end
               end
               ST_PRESSED: begin
                  if (accept) begin
                     state     <= ST_IDLE;
                     down_q    <= 1'b0;
                     release_q <= 1'b1;
                     hold_cnt  <= '0;
                  end else if (tick) begin
                     if (hold_cnt == LONG_LAST) begin
                        state    <= ST_LONG;
                        long_q   <= 1'b1;
                        hold_cnt <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
               end
               ST_LONG: begin
                  if (accept) begin
                     state     <= ST_IDLE;
                     down_q    <= 1'b0;
                     release_q <= 1'b1;
                     hold_cnt  <= '0;
                  end else if (tick) begin
                     if (hold_cnt == REPEAT_LAST) begin
                        hold_cnt <= '0;
                        repeat_q <= REPEAT_EN[i];
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  down_q   <= 1'b0;
                  hold_cnt <= '0;
               end
            endcase
         end
      end

      assign key_down[i]    = down_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_long[i]    = long_q;
      assign key_repeat[i]  = repeat_q;
   end

endmodule

// File: tb/tb_key_scan_debounce.sv
// tb/tb_key_scan_debounce.sv - self-checking bench for key_scan_debounce
module tb_key_scan_debounce;

   localparam int TD   = 4;
   localparam int DEB  = 3;
   localparam int LONG = 5;
   localparam int REP  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_in;
   logic [3:0] a_down, a_press, a_release, a_long, a_repeat;
   logic [3:0] b_down, b_press, b_release, b_long, b_repeat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_scan_debounce #(
      .NUM_KEYS(4), .TICK_DIV(TD), .DEBOUNCE_TICKS(DEB),
      .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .REPEAT_EN(4'b1111)
   ) dut_a (
      .clk(clk), .rst(rst), .key_in(key_in),
      .key_down(a_down), .key_press(a_press), .key_release(a_release),
      .key_long(a_long), .key_repeat(a_repeat)
   );

   key_scan_debounce #(
      .NUM_KEYS(4), .TICK_DIV(TD), .DEBOUNCE_TICKS(DEB),
      .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .REPEAT_EN(4'b1011)
   ) dut_b (
      .clk(clk), .rst(rst), .key_in(key_in),
      .key_down(b_down), .key_press(b_press), .key_release(b_release),
      .key_long(b_long), .key_repeat(b_repeat)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Time is counted in edges since reset; a tick is every TD-th edge.
   // Per key: ticks spent disagreeing with the debounced level, and ticks
   // held since the press was accepted (long at LONG, repeats every REP after).
   localparam logic [3:0] EN [2] = '{4'b1111, 4'b1011};
   int         cyc;
   logic [3:0] s1, s2;
   int         dticks [2][4];
   int         held   [2][4];
   logic [3:0] e_down [2], e_press [2], e_rel [2], e_long [2], e_rep [2];

   always @(posedge clk or negedge rst) begin : model
      bit m_tick;
      bit pr;
      if (!rst) begin
         cyc = 0;
         s1  = 4'hF;
         s2  = 4'hF;
         for (int d = 0; d < 2; d++) begin
            e_down[d] = 0; e_press[d] = 0; e_rel[d] = 0; e_long[d] = 0; e_rep[d] = 0;
            for (int k = 0; k < 4; k++) begin
               dticks[d][k] = 0;
               held[d][k]   = 0;
            end
         end
      end else begin
         m_tick = ((cyc % TD) == TD - 1);
         for (int d = 0; d < 2; d++) begin
            e_press[d] = 0; e_rel[d] = 0; e_long[d] = 0; e_rep[d] = 0;
            for (int k = 0; k < 4; k++) begin
               pr = !s2[k];
               if (pr != e_down[d][k]) begin
                  if (m_tick) dticks[d][k]++;
               end else begin
                  dticks[d][k] = 0;
               end
               if (dticks[d][k] == DEB) begin
                  dticks[d][k] = 0;
                  if (e_down[d][k]) begin
                     e_down[d][k] = 1'b0;
                     e_rel[d][k]  = 1'b1;
                  end else begin
                     e_down[d][k]  = 1'b1;
                     e_press[d][k] = 1'b1;
                     held[d][k]    = 0;
                  end
               end else if (e_down[d][k] && m_tick) begin
                  held[d][k]++;
                  if (held[d][k] == LONG)
                     e_long[d][k] = 1'b1;
                  else if (held[d][k] > LONG && ((held[d][k] - LONG) % REP) == 0 && EN[d][k])
                     e_rep[d][k] = 1'b1;
               end
            end
         end
         s2 = s1;
         s1 = key_in;
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         check("model_a", {a_down, a_press, a_release, a_long, a_repeat},
               {e_down[0], e_press[0], e_rel[0], e_long[0], e_rep[0]});
         check("model_b", {b_down, b_press, b_release, b_long, b_repeat},
               {e_down[1], e_press[1], e_rel[1], e_long[1], e_rep[1]});
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] a_sig(input int which);
      case (which)
         0:       return a_press;
         1:       return a_release;
         2:       return a_long;
         3:       return a_repeat;
         default: return a_down;
      endcase
   endfunction

   // Cycles until the chosen dut_a pulse shows on key k; -1 if the bound expires.
   task automatic wait_for(input int which, input int k, input int bound, output int n);
      logic [3:0] v;
      n = -1;
      for (int c = 1; c <= bound; c++) begin
         step();
         v = a_sig(which);
         if (v[k]) begin
            n = c;
            break;
         end
      end
   endtask

   typedef struct {
      logic [3:0] pins;
      int         cycles;
      logic [3:0] exp_down;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int n, first, cnt, pulses, downs, long_t, blong_t, prev, reps, brep, rel_t, brel, longs;
      int remain [4];
      logic pin;

      vecs[0] = '{4'b1110, 20, 4'b0001};
      vecs[1] = '{4'b1100, 20, 4'b0011};
      vecs[2] = '{4'b1111, 20, 4'b0000};
      vecs[3] = '{4'b0101, 20, 4'b1010};
      vecs[4] = '{4'b1111,  3, 4'b1010};
      vecs[5] = '{4'b1111, 20, 4'b0000};
      vecs[6] = '{4'b0110, 20, 4'b1001};
      vecs[7] = '{4'b1111, 20, 4'b0000};

      // Reset with all keys held, then release reset.
      rst    = 1'b0;
      key_in = 4'b0000;
      repeat (20) @(posedge clk);
      #1;
      check("reset_outputs_a", {a_down, a_press, a_release, a_long, a_repeat}, 0);
      check("reset_outputs_b", {b_down, b_press, b_release, b_long, b_repeat}, 0);
      rst   = 1'b1;
      first = -1;
      cnt   = 0;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (a_press == 4'hF) begin
            if (first < 0) first = c;
            cnt++;
         end
      end
      check_range("reset_press_latency", first, 11, 14);
      check("reset_press_once", cnt, 1);
      key_in = 4'hF;
      repeat (30) step();
      check("reset_all_released", a_down, 4'h0);

      // Clean press / release on key0.
      key_in = 4'b1110;
      wait_for(0, 0, 20, n);
      check_range("press0_latency", n, 11, 14);
      check("press0_down", a_down[0], 1'b1);
      key_in = 4'b1111;
      wait_for(1, 0, 20, n);
      check_range("release0_latency", n, 11, 14);
      check("release0_down", a_down[0], 1'b0);
      repeat (5) step();

      // Table-driven level vectors.
      for (int v = 0; v < 8; v++) begin
         key_in = vecs[v].pins;
         repeat (vecs[v].cycles) step();
         check($sformatf("table_down_%0d", v), a_down, vecs[v].exp_down);
      end

      // Bounce on key1 every 5 cycles: never accepted.
      pulses = 0;
      downs  = 0;
      pin    = 1'b1;
      for (int t = 0; t < 100; t++) begin
         if (t < 80 && (t % 5) == 0) pin = ~pin;
         if (t >= 80) pin = 1'b1;
         key_in = {2'b11, pin, 1'b1};
         step();
         if (|{a_press, a_release, a_long, a_repeat}) pulses++;
         if (a_down[1]) downs++;
      end
      check("bounce_pulses", pulses, 0);
      check("bounce_down", downs, 0);

      // Long press and repeat on key2; dut_b has repeat disabled for key2.
      key_in = 4'b1011;
      wait_for(0, 2, 20, n);
      check_range("press2_latency", n, 11, 14);
      long_t  = -1;
      blong_t = -1;
      prev    = -100;
      reps    = 0;
      brep    = 0;
      for (int t = 1; t <= 60; t++) begin
         step();
         if (a_long[2] && long_t < 0) begin
            long_t = t;
            prev   = t;
         end
         if (b_long[2] && blong_t < 0) blong_t = t;
         if (a_repeat[2]) begin
            reps++;
            check("repeat_gap", t - prev, 8);
            prev = t;
         end
         if (b_repeat[2]) brep++;
      end
      check("long2_offset", long_t, 20);
      check("long2_offset_b", blong_t, 20);
      check("repeat2_count", reps, 5);
      check("repeat2_masked", brep, 0);
      key_in = 4'hF;
      repeat (25) step();

      // Simultaneous press on key0 and key3.
      key_in = 4'b0110;
      for (int c = 0; c < 20; c++) begin
         step();
         if (a_press != 0) break;
      end
      check("simul_press", a_press, 4'b1001);
      key_in = 4'hF;
      repeat (25) step();

      // Release acceptance landing on the long terminal tick.
      key_in = 4'b1110;
      wait_for(0, 0, 20, n);
      repeat (8) @(posedge clk);
      #1;
      key_in = 4'hF;
      rel_t  = -1;
      brel   = 0;
      longs  = 0;
      for (int c = 1; c <= 25; c++) begin
         step();
         if (a_release[0] && rel_t < 0) rel_t = 8 + c;
         if (b_release[0]) brel++;
         if (a_long[0] || b_long[0]) longs++;
      end
      check("release_vs_long_time", rel_t, 20);
      check("release_vs_long_b", brel, 1);
      check("release_vs_long_nolong", longs, 0);

      // Reset in the middle of a long hold on key2.
      key_in = 4'b1011;
      wait_for(0, 2, 20, n);
      wait_for(2, 2, 30, n);
      check("prereset_long", n, 20);
      repeat (2) step();
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_a", {a_down, a_press, a_release, a_long, a_repeat}, 0);
      check("async_reset_b", {b_down, b_press, b_release, b_long, b_repeat}, 0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      wait_for(0, 2, 20, n);
      check_range("reissue_press", n, 11, 14);
      wait_for(2, 2, 30, n);
      check("reissue_long", n, 20);
      key_in = 4'hF;
      repeat (25) step();

      // Randomised pin activity checked by the model every cycle.
      for (int k = 0; k < 4; k++) remain[k] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (remain[k] == 0) begin
               key_in[k] = 1'($urandom_range(0, 1));
               remain[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 80))
                                                       : int'($urandom_range(1, 15));
            end else begin
               remain[k]--;
            end
         end
         step();
      end
      key_in = 4'hF;
      repeat (30) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
